// File: rtl/rr_arbiter.sv
// Round-robin arbiter: registered one-hot grant with a hold-time limit that forces rotation.
// Optional RR_ARB_LOCK_EN adds a 'lock' input that suppresses forced rotation while high.
module rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         request,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy
`ifdef RR_ARB_LOCK_EN
  ,
  input  logic                 lock
`endif
);

  localparam int IDW = $clog2(N);

  typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

  state_t         r_state, w_state_nxt;
  logic [N-1:0]   r_grant, w_grant_nxt;
  logic [IDW-1:0] r_id,    w_id_nxt;
  logic [IDW-1:0] r_ptr,   w_ptr_nxt;
  logic [7:0]     r_hold,  w_hold_nxt;

  logic [N-1:0]   w_arb_req;
  logic [IDW-1:0] w_win;
  logic           w_found;
  logic           w_owner_req;
  logic           w_others;
  logic           w_sat;
  logic           w_preempt;

  assign w_owner_req = |(request & r_grant);
  assign w_others    = |(request & ~r_grant);
  assign w_sat       = (r_hold == 8'(MAX_HOLD));
`ifdef RR_ARB_LOCK_EN
  assign w_preempt   = w_sat && w_others && !lock;
`else
  assign w_preempt   = w_sat && w_others;
`endif

  // The owner is always excluded from the candidate set; in IDLE r_grant is zero.
  assign w_arb_req = request & ~r_grant;

  // Circular priority scan starting at r_ptr; iterate from the far end so the
  // nearest set bit is the last one written.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_arb_req[(int'(r_ptr) + i) % N]) begin
        w_found = 1'b1;
        w_win   = IDW'((int'(r_ptr) + i) % N);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_id_nxt    = r_id;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = OWNED;
          w_grant_nxt = N'(1) << w_win;
          w_id_nxt    = w_win;
          w_ptr_nxt   = IDW'((int'(w_win) + 1) % N);
          w_hold_nxt  = 8'd1;
        end
      end
      OWNED: begin
        if (!w_owner_req || w_preempt) begin
          if (w_found) begin
            w_grant_nxt = N'(1) << w_win;
            w_id_nxt    = w_win;
            w_ptr_nxt   = IDW'((int'(w_win) + 1) % N);
            w_hold_nxt  = 8'd1;
          end else begin
            w_state_nxt = IDLE;
            w_grant_nxt = '0;
            w_id_nxt    = '0;
            w_hold_nxt  = 8'd0;
          end
        end else if (!w_sat) begin
          w_hold_nxt = r_hold + 8'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
        w_id_nxt    = '0;
        w_hold_nxt  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_id    <= '0;
      r_ptr   <= '0;
      r_hold  <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_id    <= w_id_nxt;
      r_ptr   <= w_ptr_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  assign grant    = r_grant;
  assign grant_id = r_id;
  assign busy     = |r_grant;

endmodule
